// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises bitstream words LSB-first into ccff_head,
// then optionally recirculates the chain once to compare a readback CRC against the sent CRC.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 20,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic              verify_en,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              ccff_shift_en,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int BW     = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] NW       = CNT_W'(NWORDS);

   typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

   state_t            state;
   logic [WORD_W-1:0] bbuf;
   logic [BW-1:0]     buf_cnt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  words_taken;
   logic [15:0]       crc_tx;
   logic [15:0]       crc_rx;
   logic              verify_q;
   logic              shift;
   logic              take;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   assign shift         = (state == LOAD) && (buf_cnt != '0);
   assign cfg_ready     = (state == LOAD) && (buf_cnt <= BW'(1)) && (words_taken < NW);
   assign take          = cfg_valid && cfg_ready;
   assign ccff_shift_en = shift || (state == VERIFY);
   // During readback the tail is fed back into the head so the chain contents survive.
   assign ccff_head     = (state == VERIFY) ? ccff_tail : (shift & bbuf[0]);

   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         state       <= IDLE;
         bbuf        <= '0;
         buf_cnt     <= '0;
         bit_cnt     <= '0;
         words_taken <= '0;
         crc_tx      <= 16'hFFFF;
         crc_rx      <= 16'hFFFF;
         verify_q    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state       <= LOAD;
                  busy        <= 1'b1;
                  verify_q    <= verify_en;
                  error       <= 1'b0;
                  bit_cnt     <= '0;
                  words_taken <= '0;
                  buf_cnt     <= '0;
                  crc_tx      <= 16'hFFFF;
                  crc_rx      <= 16'hFFFF;
               end
            end
            LOAD: begin
               if (shift) begin
                  crc_tx  <= crc_step(crc_tx, bbuf[0]);
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
               // A word taken while the last buffered bit leaves keeps the stream gap-free.
               if (take) begin
                  bbuf        <= cfg_data;
                  buf_cnt     <= BW'(WORD_W);
                  words_taken <= words_taken + CNT_W'(1);
               end else if (shift) begin
                  bbuf    <= bbuf >> 1;
                  buf_cnt <= buf_cnt - BW'(1);
               end
               // Final chain bit: drop any padding bits left in the last word.
               if (shift && bit_cnt == LAST_BIT) begin
                  bbuf    <= '0;
                  buf_cnt <= '0;
                  if (verify_q) begin
                     state   <= VERIFY;
                     bit_cnt <= '0;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            VERIFY: begin
               crc_rx  <= crc_step(crc_rx, ccff_tail);
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
               if (verify_q) error <= (crc_rx != crc_tx);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
